// File: rtl/shift_add_multiplier_ctrl.sv
// Sequential 4x4 unsigned shift-and-add multiplier driving an external 4-bit ripple-carry adder.
// Optional feature: define MUL_ZERO_BYPASS_EN to skip the RUN phase when an operand is zero.
module shift_add_multiplier_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_s,
    input  logic               add_cout
);

    if (WIDTH != 4) begin : g_width_check
        $error("shift_add_multiplier_ctrl: only WIDTH=4 is supported");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_bypass;
    logic               w_last;

`ifdef MUL_ZERO_BYPASS_EN
    assign w_bypass = (in_a == '0) || (in_b == '0);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_state_next = w_bypass ? StDone : StRun;
                end
            end
            StRun: begin
                if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Each RUN edge shifts the 9-bit adder result plus Q right by one into {ACC,Q}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m   <= '0;
            r_acc <= '0;
            r_q   <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_m   <= in_a;
                        r_q   <= w_bypass ? '0 : in_b;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                StRun: begin
                    {r_acc, r_q} <= {add_cout, add_s, r_q[WIDTH-1:1]};
                    r_cnt        <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_p     = '0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        case (r_state)
            StIdle: begin
                in_ready = 1'b1;
            end
            StRun: begin
                add_a = r_acc;
                add_b = r_q[0] ? r_m : '0;
            end
            StDone: begin
                out_valid = 1'b1;
                out_p     = {r_acc, r_q};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shift_add_multiplier_ctrl.sv
// Self-checking bench for shift_add_multiplier_ctrl with a behavioural adder and product model.
// Honours MUL_ZERO_BYPASS_EN when the design is built with it.
module tb_shift_add_multiplier_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_p;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_cin;
    logic [3:0] add_s;
    logic       add_cout;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    time         last_acc = 0;
    bit          saw_cout;

`ifdef MUL_ZERO_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    shift_add_multiplier_ctrl #(
        .WIDTH(4),
        .CNT_W(2)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_p    (out_p),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    // Behavioural stand-in for the external 4-bit ripple-carry adder.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_outs(input string pfx);
        check_eq({pfx, "_in_ready"}, in_ready, 1);
        check_eq({pfx, "_out_valid"}, out_valid, 0);
        check_eq({pfx, "_out_p"}, out_p, 0);
        check_eq({pfx, "_add_a"}, add_a, 0);
        check_eq({pfx, "_add_b"}, add_b, 0);
        check_eq({pfx, "_add_cin"}, add_cin, 0);
    endtask

    // Called and returns at a negedge with the DUT idle (or just reset).
    task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input int stall,
                           input bit keep_valid, input int abort_at, input bit chk_spacing);
        int          waitc;
        int          nrun;
        int unsigned prod;
        out_ready = (stall == 0);
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        waitc     = 0;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 20) begin
            check_eq("accept_timeout", waitc, 0);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (chk_spacing) check_eq("accept_spacing", int'(($time - last_acc) / 10), 6);
        last_acc = $time;
        @(negedge clk);
        if (!keep_valid) in_valid = 1'b0;
        nrun     = (Bypass && (a == 0 || b == 0)) ? 0 : 4;
        saw_cout = 1'b0;
        for (int k = 0; k < nrun; k++) begin
            check_eq("run_in_ready", in_ready, 0);
            check_eq("run_out_valid", out_valid, 0);
            check_eq("run_out_p", out_p, 0);
            check_eq("run_add_cin", add_cin, 0);
            // Accumulator after k steps holds the partial product of the low k multiplier bits.
            check_eq("run_add_a", add_a, (a * (b & ((1 << k) - 1))) >> k);
            check_eq("run_add_b", add_b, b[k] ? a : 0);
            if (add_cout) saw_cout = 1'b1;
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outs("abort");
                @(negedge clk);
                check_reset_outs("abort_hold");
                rst_n    = 1'b1;
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        prod = a * b;
        check_eq("done_out_valid", out_valid, 1);
        check_eq("done_out_p", out_p, prod);
        check_eq("done_in_ready", in_ready, 0);
        check_eq("done_add_a", add_a, 0);
        check_eq("done_add_b", add_b, 0);
        if (stall > 0) begin
            in_a     = 4'd2;
            in_b     = 4'd2;
            in_valid = 1'b1;
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_eq("stall_out_valid", out_valid, 1);
            check_eq("stall_out_p", out_p, prod);
            check_eq("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("idle_out_valid", out_valid, 0);
        check_eq("idle_out_p", out_p, 0);
        check_eq("idle_in_ready", in_ready, 1);
        if (prod == 225 && nrun == 4) check_eq("cout_seen", saw_cout, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outs("post_reset");

        run_txn(4'd15, 4'd15, 0, 1'b0, -1, 1'b0);
        run_txn(4'd7, 4'd6, 0, 1'b0, -1, 1'b0);
        run_txn(4'd0, 4'd9, 0, 1'b0, -1, 1'b0);
        run_txn(4'd5, 4'd3, 3, 1'b0, -1, 1'b0);
        run_txn(4'd2, 4'd2, 0, 1'b0, -1, 1'b0);
        run_txn(4'd9, 4'd11, 0, 1'b0, 2, 1'b0);
        run_txn(4'd3, 4'd4, 0, 1'b0, -1, 1'b0);

        repeat (40) begin
            run_txn(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 2)), 1'b0, -1, 1'b0);
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_txn(4'(a), 4'(b), 0, 1'b1, -1, !(a == 0 && b == 0));
            end
        end
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
